// File: rtl/merge_pkg.sv
// Shared constants and lane arithmetic for the partial-sum merge router.
package merge_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_XM    = 1;
  localparam int PORT_XP    = 2;
  localparam int PORT_YP    = 3;
  localparam int PORT_YM    = 4;
  localparam int NUM_DIRS   = 5;

  // Accumulator width that can hold the sum of n signed lw-bit values.
  function automatic int acc_width(input int lw, input int n);
    return lw + $clog2(n);
  endfunction

  // Reduce a full-precision lane sum to lw bits; returns {overflow, value}.
  // Only the low lw bits of the value are meaningful to the caller.
  function automatic logic [64:0] lane_add_sat(input logic signed [63:0] acc,
                                               input int lw, input int sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    logic               ovf;
    hi  = (64'sd1 <<< (lw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (lw - 1));
    ovf = (acc > hi) || (acc < lo);
    res = acc;
    if (sat != 0 && acc > hi) res = hi;
    else if (sat != 0 && acc < lo) res = lo;
    return {ovf, res};
  endfunction

endpackage

// File: rtl/merge_fifo.sv
// Per-input synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module merge_fifo #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [DW-1:0] mem [FIFO_DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_merge_router.sv
// Joins partial-sum flits from the masked input ports, adds them lane-wise and
// multicasts the merged flit to the selected output ports.
module psum_merge_router
  import merge_pkg::*;
#(
  parameter int                   NUM_PORTS  = NUM_DIRS,
  parameter int                   DW         = 32,
  parameter int                   LANES      = 4,
  parameter logic [NUM_PORTS-1:0] INPUT_MASK = NUM_PORTS'(1),
  parameter logic [NUM_PORTS-1:0] OUTPUT_SEL = NUM_PORTS'(4),
  parameter int                   FIFO_DEPTH = 4,
  parameter int                   SAT_MODE   = 0,
  parameter int                   CW         = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS*DW-1:0] data_i,
  input  logic [NUM_PORTS-1:0]    valid_i,
  output logic [NUM_PORTS-1:0]    ready_o,
  output logic [NUM_PORTS*DW-1:0] data_o,
  output logic [NUM_PORTS-1:0]    valid_o,
  input  logic [NUM_PORTS-1:0]    ready_i,
  output logic                    ovf_o,
  output logic [CW-1:0]           merge_cnt_o
);

  localparam int LW    = DW / LANES;
  localparam int ACC_W = acc_width(LW, NUM_PORTS);

  if (INPUT_MASK == '0) begin : g_bad_mask
    $fatal(1, "psum_merge_router: INPUT_MASK must select at least one port");
  end
  if (OUTPUT_SEL == '0) begin : g_bad_sel
    $fatal(1, "psum_merge_router: OUTPUT_SEL must select at least one port");
  end
  if ((DW % LANES) != 0) begin : g_bad_lanes
    $fatal(1, "psum_merge_router: DW must be a multiple of LANES");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "psum_merge_router: FIFO_DEPTH must be a power of 2 >= 2");
  end
  if (ACC_W > 64) begin : g_bad_width
    $fatal(1, "psum_merge_router: lane accumulator wider than 64 bits");
  end

  logic [NUM_PORTS-1:0][DW-1:0] fifo_dout;
  logic [NUM_PORTS-1:0]         fifo_full;
  logic [NUM_PORTS-1:0]         fifo_empty;
  logic [NUM_PORTS-1:0]         fifo_push;
  logic [NUM_PORTS-1:0]         fifo_pop;

  logic                    vld_p1;
  logic [NUM_PORTS-1:0]    pend_p1;
  logic [DW-1:0]           data_p1;
  logic                    ovf_p1;
  logic [CW-1:0]           cnt_p1;
  logic                    done_p1;

  logic                    join_rdy_p0;
  logic                    fire_p0;
  logic [DW-1:0]           merged_p0;
  logic                    ovf_p0;
  logic signed [ACC_W-1:0] acc;
  logic [LANES-1:0][64:0]  lane_r;

  assign ready_o   = rst ? '0 : (INPUT_MASK & ~fifo_full);
  assign fifo_push = valid_i & ready_o;
  assign fifo_pop  = fire_p0 ? INPUT_MASK : '0;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    if (INPUT_MASK[p]) begin : g_fifo
      merge_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push[p]),
        .din   (data_i[p*DW +: DW]),
        .pop   (fifo_pop[p]),
        .dout  (fifo_dout[p]),
        .full  (fifo_full[p]),
        .empty (fifo_empty[p])
      );
    end else begin : g_off
      assign fifo_dout[p]  = '0;
      assign fifo_full[p]  = 1'b1;
      assign fifo_empty[p] = 1'b1;
    end
  end

  // Stage p0: join the FIFO heads and reduce each lane.
  assign done_p1     = vld_p1 && ((pend_p1 & ~ready_i) == '0);
  assign join_rdy_p0 = ((~fifo_empty & INPUT_MASK) == INPUT_MASK);
  assign fire_p0     = join_rdy_p0 && (!vld_p1 || done_p1);

  always_comb begin
    merged_p0 = '0;
    ovf_p0    = 1'b0;
    lane_r    = '0;
    acc       = '0;
    for (int l = 0; l < LANES; l++) begin
      acc = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (INPUT_MASK[p]) acc = acc + ACC_W'(signed'(fifo_dout[p][l*LW +: LW]));
      end
      lane_r[l]               = lane_add_sat(64'(acc), LW, SAT_MODE);
      merged_p0[l*LW +: LW]   = lane_r[l][LW-1:0];
      ovf_p0                  = ovf_p0 | lane_r[l][64];
    end
  end

  // Stage p1: output register, held until every selected port has taken it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      pend_p1 <= '0;
      data_p1 <= '0;
      ovf_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      ovf_p1 <= fire_p0 & ovf_p0;
      if (done_p1) cnt_p1 <= cnt_p1 + 1'b1;
      if (fire_p0) begin
        vld_p1  <= 1'b1;
        pend_p1 <= OUTPUT_SEL;
        data_p1 <= merged_p0;
      end else if (done_p1) begin
        vld_p1  <= 1'b0;
        pend_p1 <= '0;
      end else begin
        pend_p1 <= pend_p1 & ~ready_i;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    assign data_o[p*DW +: DW] = OUTPUT_SEL[p] ? data_p1 : '0;
  end

  assign valid_o     = (vld_p1 && !rst) ? pend_p1 : '0;
  assign ovf_o       = ovf_p1;
  assign merge_cnt_o = cnt_p1;

  // Inputs of unmasked ports and the upper bits of each lane result are don't-cares.
  logic unused_ok;
  assign unused_ok = ^{data_i, valid_i, lane_r};

endmodule

// File: tb/tb_psum_merge_router.sv
// Directed bench: three router configurations, a queue-based model of the
// 3-input instance compared every cycle, plus hand-computed spot values.
module tb_psum_merge_router;

  localparam int NP = 5;
  localparam int DW = 32;
  localparam logic [4:0] A_SEL = 5'b01110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP*DW-1:0] a_data_i, a_data_o, b_data_i, b_data_o, c_data_i, c_data_o;
  logic [NP-1:0]    a_valid_i, a_ready_o, a_valid_o, a_ready_i;
  logic [NP-1:0]    b_valid_i, b_ready_o, b_valid_o, b_ready_i;
  logic [NP-1:0]    c_valid_i, c_ready_o, c_valid_o, c_ready_i;
  logic             a_ovf, b_ovf, c_ovf;
  logic [15:0]      a_cnt, b_cnt, c_cnt;

  psum_merge_router #(.INPUT_MASK(5'b00111), .OUTPUT_SEL(A_SEL), .SAT_MODE(0)) u_a (
    .clk(clk), .rst(rst), .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i), .ovf_o(a_ovf),
    .merge_cnt_o(a_cnt));

  psum_merge_router #(.INPUT_MASK(5'b00011), .OUTPUT_SEL(5'b00100), .SAT_MODE(1)) u_b (
    .clk(clk), .rst(rst), .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i), .ovf_o(b_ovf),
    .merge_cnt_o(b_cnt));

  psum_merge_router u_c (
    .clk(clk), .rst(rst), .data_i(c_data_i), .valid_i(c_valid_i), .ready_o(c_ready_o),
    .data_o(c_data_o), .valid_o(c_valid_o), .ready_i(c_ready_i), .ovf_o(c_ovf),
    .merge_cnt_o(c_cnt));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] port_of(input logic [NP*DW-1:0] d, input int p);
    return d[p*DW +: DW];
  endfunction

  // Lane-wise wrapping sum of three flits of four signed bytes; returns {ovf, data}.
  function automatic logic [32:0] merge3(input logic [31:0] x0, input logic [31:0] x1,
                                         input logic [31:0] x2);
    logic [31:0] r;
    logic        o;
    int          s;
    r = '0;
    o = 1'b0;
    for (int l = 0; l < 4; l++) begin
      s = int'($signed(x0[l*8 +: 8])) + int'($signed(x1[l*8 +: 8])) + int'($signed(x2[l*8 +: 8]));
      if (s > 127 || s < -128) o = 1'b1;
      r[l*8 +: 8] = s[7:0];
    end
    return {o, r};
  endfunction

  // Model of instance a: per-port arrival queues and one multicast slot.
  logic [31:0] mq [3][$];
  logic        m_vld  = 1'b0;
  logic [4:0]  m_pend = '0;
  logic [31:0] m_data = '0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_cnt  = '0;

  initial begin : model
    logic [2:0]  take;
    logic        done, fire;
    logic [32:0] mr;
    logic [31:0] h0, h1, h2;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int p = 0; p < 3; p++) mq[p].delete();
        m_vld = 1'b0; m_pend = '0; m_data = '0; m_ovf = 1'b0; m_cnt = '0;
      end else begin
        for (int p = 0; p < 3; p++) take[p] = a_valid_i[p] && (mq[p].size() < 4);
        done  = m_vld && ((m_pend & ~a_ready_i) == '0);
        fire  = (mq[0].size() > 0) && (mq[1].size() > 0) && (mq[2].size() > 0) && (!m_vld || done);
        m_ovf = 1'b0;
        if (done) m_cnt = m_cnt + 16'd1;
        if (fire) begin
          h0 = mq[0].pop_front();
          h1 = mq[1].pop_front();
          h2 = mq[2].pop_front();
          mr = merge3(h0, h1, h2);
          m_vld = 1'b1; m_pend = A_SEL; m_data = mr[31:0]; m_ovf = mr[32];
        end else if (done) begin
          m_vld = 1'b0; m_pend = '0;
        end else begin
          m_pend = m_pend & ~a_ready_i;
        end
        for (int p = 0; p < 3; p++) if (take[p]) mq[p].push_back(a_data_i[p*DW +: DW]);
      end
    end
  end

  initial begin : compare
    logic [4:0] er;
    forever begin
      @(negedge clk);
      er = '0;
      for (int p = 0; p < 3; p++) er[p] = !rst && (mq[p].size() < 4);
      chk("a_ready_o", 32'(a_ready_o), 32'(er));
      chk("a_valid_o", 32'(a_valid_o), (m_vld && !rst) ? 32'(m_pend) : 32'd0);
      for (int p = 0; p < NP; p++)
        chk($sformatf("a_data_o[%0d]", p), port_of(a_data_o, p), A_SEL[p] ? m_data : 32'd0);
      chk("a_ovf_o", 32'(a_ovf), 32'(m_ovf));
      chk("a_merge_cnt_o", 32'(a_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [4:0] v);
    a_data_i = {64'd0, d2, d1, d0};
    a_valid_i = v;
  endtask

  logic [4:0] rdy_tab [6] = '{5'b00010, 5'b00010, 5'b00110, 5'b00010, 5'b00010, 5'b01010};
  logic [4:0] vld_tab [6] = '{5'b01100, 5'b01100, 5'b01000, 5'b01000, 5'b01000, 5'b01110};
  int sent;

  initial begin
    a_data_i = '0; a_valid_i = '0; a_ready_i = '0;
    b_data_i = '0; b_valid_i = '0; b_ready_i = '0;
    c_data_i = '0; c_valid_i = '0; c_ready_i = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset a_ready_o", 32'(a_ready_o), 32'd0);
    chk("reset a_valid_o", 32'(a_valid_o), 32'd0);
    chk("reset a_cnt", 32'(a_cnt), 32'd0);
    chk("reset b_ready_o", 32'(b_ready_o), 32'd0);
    chk("reset c_data_o[2]", port_of(c_data_o, 2), 32'd0);
    rst = 1'b0;
    tick();
    chk("c_ready_o after reset", 32'(c_ready_o), 32'h01);

    // Pass-through (c) and saturation (b) in parallel.
    b_ready_i = 5'b00100;
    c_ready_i = 5'b00100;
    c_data_i[31:0] = 32'h0102_0304; c_valid_i = 5'b00001;
    b_data_i[63:0] = {32'h0101_0180, 32'h7F7F_FF80}; b_valid_i = 5'b00011;
    tick();
    c_valid_i = '0; b_valid_i = '0;
    chk("c_valid_o one cycle after handshake", 32'(c_valid_o), 32'd0);
    tick();
    chk("c_valid_o two cycles after handshake", 32'(c_valid_o), 32'h04);
    for (int p = 0; p < NP; p++)
      chk($sformatf("c_data_o[%0d]", p), port_of(c_data_o, p), (p == 2) ? 32'h0102_0304 : 32'd0);
    chk("b_valid_o sat flit", 32'(b_valid_o), 32'h04);
    chk("b_data_o sat flit", port_of(b_data_o, 2), 32'h7F7F_0080);
    chk("b_ovf_o sat flit", 32'(b_ovf), 32'd1);
    b_data_i[63:0] = {32'h0101_0101, 32'hFFFF_FFFF}; b_valid_i = 5'b00011;
    tick();
    b_valid_i = '0;
    chk("c_merge_cnt_o", 32'(c_cnt), 32'd1);
    chk("c_valid_o after delivery", 32'(c_valid_o), 32'd0);
    chk("b_ovf_o single cycle", 32'(b_ovf), 32'd0);
    chk("b_merge_cnt_o first", 32'(b_cnt), 32'd1);
    tick();
    chk("b_data_o -1+1", port_of(b_data_o, 2), 32'd0);
    chk("b_ovf_o -1+1", 32'(b_ovf), 32'd0);
    tick();
    chk("b_merge_cnt_o second", 32'(b_cnt), 32'd2);

    // Three-way join with staggered arrivals.
    a_ready_i = A_SEL;
    drive_a(32'h1010_1010, 32'd0, 32'd0, 5'b00001); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);         tick();
    drive_a(32'd0, 32'h2020_2020, 32'd0, 5'b00010); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);         tick();
    chk("join waits for port 2", 32'(a_valid_o), 32'd0);
    drive_a(32'd0, 32'd0, 32'h3030_3030, 5'b00100); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);
    chk("join still waiting", 32'(a_valid_o), 32'd0);
    tick();
    chk("join valid", 32'(a_valid_o), 32'(A_SEL));
    chk("join data", port_of(a_data_o, 1), 32'h6060_6060);
    tick();
    chk("join count", 32'(a_cnt), 32'd1);

    // Wrapping overflow, then -1 + 1.
    drive_a(32'h7F7F_7F7F, 32'h0101_0101, 32'd0, 5'b00111); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);                 tick();
    chk("wrap data", port_of(a_data_o, 2), 32'h8080_8080);
    chk("wrap ovf", 32'(a_ovf), 32'd1);
    drive_a(32'hFFFF_FFFF, 32'h0101_0101, 32'd0, 5'b00111); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);
    chk("wrap ovf single cycle", 32'(a_ovf), 32'd0);
    tick();
    chk("-1+1 data", port_of(a_data_o, 2), 32'd0);
    chk("-1+1 ovf", 32'(a_ovf), 32'd0);
    tick();
    chk("count after overflow pair", 32'(a_cnt), 32'd3);

    // Multicast with independent per-port backpressure.
    drive_a(32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 5'b00111); tick();
    drive_a(32'h0404_0404, 32'h0505_0505, 32'h0606_0606, 5'b00111); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);
    chk("mcast first valid", 32'(a_valid_o), 32'(A_SEL));
    chk("mcast first data", port_of(a_data_o, 3), 32'h0606_0606);
    for (int i = 0; i < 6; i++) begin
      a_ready_i = rdy_tab[i];
      tick();
      chk($sformatf("mcast pending step %0d", i), 32'(a_valid_o), 32'(vld_tab[i]));
    end
    chk("mcast second data", port_of(a_data_o, 3), 32'h0F0F_0F0F);
    chk("mcast count", 32'(a_cnt), 32'd4);
    a_ready_i = A_SEL;
    tick();
    chk("mcast drained", 32'(a_valid_o), 32'd0);

    // FIFO full on port 0 while ports 1/2 are idle.
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      a_data_i[31:0] = 32'(sent + 1);
      a_valid_i = 5'b00001;
      if (a_ready_o[0]) sent++;
      tick();
    end
    a_valid_i = '0;
    chk("fifo accepted", 32'(sent), 32'd4);
    chk("fifo full ready", 32'(a_ready_o[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive_a(32'd0, 32'h0100_0000 * 32'(k + 1), 32'h0001_0000, 5'b00110);
      tick();
      if (k == 0) chk("ready before first pop", 32'(a_ready_o[0]), 32'd0);
      if (k == 1) chk("ready after first pop", 32'(a_ready_o[0]), 32'd1);
    end
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);
    repeat (3) tick();
    chk("fifo merges counted", 32'(a_cnt), 32'd9);

    // Reset while one port of a multicast is still pending.
    a_ready_i = 5'b00110;
    drive_a(32'h0101_0101, 32'h0101_0101, 32'h0101_0101, 5'b00111); tick();
    drive_a(32'h0202_0202, 32'h0202_0202, 32'h0202_0202, 5'b00111); tick();
    drive_a(32'h0303_0303, 32'h0303_0303, 32'h0303_0303, 5'b00111); tick();
    drive_a(32'd0, 32'd0, 32'd0, 5'b00000);                         tick();
    chk("pending before reset", 32'(a_valid_o), 32'h08);
    rst = 1'b1;
    tick();
    chk("reset valid_o", 32'(a_valid_o), 32'd0);
    chk("reset ready_o", 32'(a_ready_o), 32'd0);
    chk("reset merge_cnt_o", 32'(a_cnt), 32'd0);
    rst = 1'b0;
    a_ready_i = A_SEL;
    repeat (5) tick();
    chk("no stale flit", 32'(a_valid_o), 32'd0);
    chk("no stale count", 32'(a_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
